// File: rtl/pixel_scale_pkg.sv
// Shared defaults and width helpers for the pixel scaling pipeline.
// Optional saturation is selected with the PIXEL_SCALE_SAT_EN macro
// (see pixel_scale_lane.sv); without it results wrap.
package pixel_scale_pkg;

  localparam int LANES_DEF     = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int COEF_W_DEF    = 8;
  localparam int FRAC_BITS_DEF = 6;
  localparam int OUT_W_DEF     = 8;

  // Full-precision product width: no bits lost in the multiply.
  function automatic int prod_width(input int dw, input int cw);
    return dw + cw;
  endfunction

  // One guard bit above the product so adding the rounding half can never
  // overflow, even for the most negative * most negative corner.
  function automatic int rnd_width(input int dw, input int cw);
    return dw + cw + 1;
  endfunction

  localparam int PROD_W_DEF = prod_width(DATA_W_DEF, COEF_W_DEF);
  localparam int RND_W_DEF  = rnd_width(DATA_W_DEF, COEF_W_DEF);

endpackage

// File: rtl/pixel_scale_lane.sv
// Single-lane datapath: signed multiply (S1 register), round-half-up and
// clamp or wrap (S2 register). Enables come from the shared handshake in
// the top. PIXEL_SCALE_SAT_EN defined -> clamp with sat flag; undefined ->
// low OUT_W bits of the rounded value, sat tied 0.
module pixel_scale_lane
  import pixel_scale_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int COEF_W    = COEF_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int OUT_W     = OUT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en1,
  input  logic              en2,
  input  logic [DATA_W-1:0] pixel,
  input  logic [COEF_W-1:0] coef,
  output logic [OUT_W-1:0]  res,
  output logic              sat
);

  localparam int PW = prod_width(DATA_W, COEF_W);
  localparam int RW = rnd_width(DATA_W, COEF_W);

  logic signed [PW-1:0] pix_x, coef_x, prod_d, prod_q;
  logic signed [RW-1:0] prod_x, rnd_w;
  logic [OUT_W-1:0]     res_d;
  logic                 sat_d;

  // Sign-extend both operands to product width so the multiply is exact.
  assign pix_x  = PW'($signed(pixel));
  assign coef_x = PW'($signed(coef));
  assign prod_d = pix_x * coef_x;

  // S1: capture the product only for a real accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   prod_q <= '0;
    else if (en1) prod_q <= prod_d;
  end

  assign prod_x = {prod_q[PW-1], prod_q};

  generate
    if (FRAC_BITS > 0) begin : g_rnd
      localparam logic signed [RW-1:0] HALF = {{(RW-1){1'b0}}, 1'b1} << (FRAC_BITS-1);
      assign rnd_w = (prod_x + HALF) >>> FRAC_BITS;
    end else begin : g_nornd
      assign rnd_w = prod_x;
    end
  endgenerate

`ifdef PIXEL_SCALE_SAT_EN
  localparam logic signed [RW-1:0] MAXV = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Clamp into the signed OUT_W range and flag any clamping.
  always_comb begin
    res_d = rnd_w[OUT_W-1:0];
    sat_d = 1'b0;
    if (rnd_w > MAXV) begin
      res_d = MAXV[OUT_W-1:0];
      sat_d = 1'b1;
    end else if (rnd_w < MINV) begin
      res_d = MINV[OUT_W-1:0];
      sat_d = 1'b1;
    end
  end
`else
  // Wrap mode keeps the low bits only; the discarded high bits are dead.
  logic unused_hi;
  assign unused_hi = ^rnd_w[RW-1:OUT_W];
  assign res_d     = rnd_w[OUT_W-1:0];
  assign sat_d     = 1'b0;
`endif

  // S2: result holds while the output stage is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res <= '0;
      sat <= 1'b0;
    end else if (en2) begin
      res <= res_d;
      sat <= sat_d;
    end
  end

endmodule

// File: rtl/pixel_scale_pipe.sv
// Two-stage multi-lane pixel scaler with valid/ready handshake.
// Lanes are independent pixel_scale_lane instances sharing one coefficient
// and one pair of stage enables. PIXEL_SCALE_SAT_EN selects saturation.
module pixel_scale_pipe
  import pixel_scale_pkg::*;
#(
  parameter int LANES     = LANES_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int COEF_W    = COEF_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int OUT_W     = OUT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_pixel,
  input  logic [COEF_W-1:0]       coef,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*OUT_W-1:0]  out_pixel,
  output logic [LANES-1:0]        sat_flag
);

  localparam int STAGES = 2;

  logic [STAGES:1]              vld_pipe;
  logic                         adv1, adv2;
  logic [LANES-1:0][DATA_W-1:0] pix_a;
  logic [LANES-1:0][OUT_W-1:0]  res_a;

  // A stage moves when it is empty or the stage after it moves.
  assign adv2      = !vld_pipe[2] || out_ready;
  assign adv1      = !vld_pipe[1] || adv2;
  assign in_ready  = adv1;
  assign out_valid = vld_pipe[2];

  assign pix_a     = in_pixel;
  assign out_pixel = res_a;

  // Valid shift register with per-stage stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      if (adv1) vld_pipe[1] <= in_valid;
      if (adv2) vld_pipe[2] <= vld_pipe[1];
    end
  end

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      pixel_scale_lane #(
        .DATA_W    (DATA_W),
        .COEF_W    (COEF_W),
        .FRAC_BITS (FRAC_BITS),
        .OUT_W     (OUT_W)
      ) u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .en1   (adv1 && in_valid),
        .en2   (adv2 && vld_pipe[1]),
        .pixel (pix_a[k]),
        .coef  (coef),
        .res   (res_a[k]),
        .sat   (sat_flag[k])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pixel_scale_pipe.sv
// Directed bench for pixel_scale_pipe: table of single-beat vectors plus
// hand-written backpressure, streaming and mid-stream reset sequences.
module tb_pixel_scale_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pixel;
  logic [7:0]  coef;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pixel;
  logic [3:0]  sat_flag;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  pixel_scale_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .coef      (coef),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pixel (out_pixel),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string           name;
    logic [3:0][7:0] pix;
    logic [7:0]      cf;
    logic [3:0][7:0] exp;
    logic [3:0]      sat;
  } vec_t;

  vec_t tv[6];

  // Monitor: records handshakes, sampled mid-cycle.
  logic [31:0] got_q[$];
  int          got_cyc[$];
  int          acc_cyc[$];
  bit          mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (out_valid && out_ready) begin
        got_q.push_back(out_pixel);
        got_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) acc_cyc.push_back(cyc);
    end
  end

  function automatic logic [3:0][7:0] mk(input int a, input int b, input int c, input int d);
    logic [3:0][7:0] r;
    r[0] = a[7:0];
    r[1] = b[7:0];
    r[2] = c[7:0];
    r[3] = d[7:0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_got(input int n);
    int t = 0;
    while (got_q.size() < n && t < 60) begin
      @(posedge clk);
      #2;
      t++;
    end
    chk("out_count", 64'(got_q.size()), 64'(n));
  endtask

  initial begin
    logic [3:0][7:0] a, b, c, x, z;

    tv[0] = '{"unity",    mk(50, -37, 0, 127),    8'd64,  mk(50, -37, 0, 127), 4'b0000};
    tv[1] = '{"half",     mk(-37, 50, 1, -1),     8'd32,  mk(-18, 25, 1, 0),   4'b0000};
`ifdef PIXEL_SCALE_SAT_EN
    tv[2] = '{"big_pos",  mk(100, -128, 2, -1),   8'd127, mk(127, -128, 4, -2), 4'b0011};
    tv[3] = '{"neg_neg",  mk(-128, 1, -1, 0),     8'h80,  mk(127, -2, 2, 0),   4'b0001};
`else
    tv[2] = '{"big_pos",  mk(100, -128, 2, -1),   8'd127, mk(-58, 2, 4, -2),   4'b0000};
    tv[3] = '{"neg_neg",  mk(-128, 1, -1, 0),     8'h80,  mk(0, -2, 2, 0),     4'b0000};
`endif
    tv[4] = '{"zero",     mk(5, -5, 100, -100),   8'd0,   mk(0, 0, 0, 0),      4'b0000};
    tv[5] = '{"rnd_edge", mk(31, 32, -32, -33),   8'd1,   mk(0, 1, 0, -1),     4'b0000};

    rst_n = 1'b0; in_valid = 1'b0; in_pixel = '0; coef = '0; out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pixel", out_pixel, 0);
    chk("rst_sat_flag",  sat_flag,  0);
    chk("rst_in_ready",  in_ready,  1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Table: one beat each, latency 2 with out_ready high
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_pixel = tv[i].pix; coef = tv[i].cf;
      @(negedge clk);
      chk({tv[i].name, "_in_ready"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_pixel = $urandom; coef = 8'($urandom);
      @(negedge clk);
      chk({tv[i].name, "_early"}, out_valid, 0);
      @(posedge clk);
      @(negedge clk);
      chk({tv[i].name, "_valid"}, out_valid, 1);
      chk({tv[i].name, "_pixel"}, out_pixel, tv[i].exp);
      chk({tv[i].name, "_sat"},   sat_flag,  tv[i].sat);
    end

    // Idle with junk inputs: no state change
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 in_pixel = $urandom; coef = 8'($urandom);
    end
    @(negedge clk);
    chk("idle_valid", out_valid, 0);
    chk("idle_hold",  out_pixel, tv[5].exp);

    // Backpressure: 3 beats offered with out_ready low for 5 cycles
    a = mk(1, 2, 3, 4); b = mk(-5, 6, -7, 8); c = mk(9, 10, 11, 12);
    @(posedge clk); #1;
    got_q.delete(); got_cyc.delete(); acc_cyc.delete(); mon_en = 1'b1;
    out_ready = 1'b0; coef = 8'd64; in_valid = 1'b1; in_pixel = a;
    @(posedge clk); #1 in_pixel = b;
    @(posedge clk); #1 in_pixel = c;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid",    out_valid, 1);
      chk("bp_stable",   out_pixel, a);
      @(posedge clk); #1;
    end
    chk("bp_accepted", 64'(acc_cyc.size()), 2);
    chk("bp_no_emit",  64'(got_q.size()), 0);
    out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_got(3);
    if (got_q.size() >= 3) begin
      chk("bp_order0", got_q[0], a);
      chk("bp_order1", got_q[1], b);
      chk("bp_order2", got_q[2], c);
    end
    chk("bp_total_acc", 64'(acc_cyc.size()), 3);

    // Streaming: 16 back-to-back beats
    @(posedge clk); #1;
    got_q.delete(); got_cyc.delete(); acc_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_pixel = mk(i, -i, 2*i, 100-i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_got(16);
    chk("st_acc_count", 64'(acc_cyc.size()), 16);
    if (got_q.size() == 16 && acc_cyc.size() == 16) begin
      chk("st_latency", 64'(got_cyc[0] - acc_cyc[0]), 2);
      for (int i = 0; i < 16; i++) begin
        chk("st_data", got_q[i], mk(i, -i, 2*i, 100-i));
        chk("st_consec", 64'(got_cyc[i] - got_cyc[0]), 64'(i));
      end
    end

    // Reset with two beats in flight
    x = mk(7, 7, 7, 7);
    @(posedge clk); #1;
    got_q.delete(); got_cyc.delete(); acc_cyc.delete();
    in_valid = 1'b1; in_pixel = x;
    @(posedge clk); #1 in_pixel = mk(8, 8, 8, 8);
    @(posedge clk); #1 in_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("mr_async_valid", out_valid, 0);
    chk("mr_async_pixel", out_pixel, 0);
    @(negedge clk);
    chk("mr_in_ready", in_ready, 1);
    chk("mr_sat",      sat_flag, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    acc_cyc.delete();
    for (int i = 0; i < 4; i++) @(posedge clk);
    #1;
    chk("mr_no_emit", 64'(got_q.size()), 0);
    z = mk(-20, 30, -40, 60);
    in_valid = 1'b1; in_pixel = z;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_got(1);
    if (got_q.size() >= 1 && acc_cyc.size() >= 1) begin
      chk("mr_new_data", got_q[0], z);
      chk("mr_latency",  64'(got_cyc[0] - acc_cyc[0]), 2);
    end
    chk("mr_only_one", 64'(got_q.size()), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_scale_pipe.md
PIXEL_SCALE_PIPE -- requirements
Module: pixel_scale_pipe

Interface
REQ-001 Parameter: LANES, default 4, number of pixel channels processed per beat.
REQ-002 Parameter: DATA_W, default 8, signed pixel width per lane.
REQ-003 Parameter: COEF_W, default 8, signed coefficient width.
REQ-004 Parameter: FRAC_BITS, default 6, fractional bits of coefficient (64 = 1.0 at default).
REQ-005 Parameter: OUT_W, default 8, signed result width per lane.
REQ-006 Port: clk  in  1  single clock, all logic rising-edge.
REQ-007 Port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 Port: in_valid  in  1  input beat valid.
REQ-009 Port: in_ready  out  1  block accepts beat when in_valid && in_ready.
REQ-010 Port: in_pixel  in  LANES*DATA_W  signed pixels, lane k at bits [k*DATA_W +: DATA_W].
REQ-011 Port: coef  in  COEF_W  signed coefficient, applied to all lanes of the accepted beat.
REQ-012 Port: out_valid  out  1  output beat valid.
REQ-013 Port: out_ready  in  1  downstream accepts when out_valid && out_ready.
REQ-014 Port: out_pixel  out  LANES*OUT_W  scaled pixels, same lane packing.
REQ-015 Port: sat_flag  out  LANES  per-lane saturation occurred for the current output beat.

Function
REQ-016 Per lane: product = pixel * coef, full width DATA_W+COEF_W signed, no truncation.
REQ-017 Rounding: add 2^(FRAC_BITS-1) then arithmetic shift right FRAC_BITS (round half up); FRAC_BITS=0 skips rounding.
REQ-018 Result clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; sat_flag[k]=1 iff lane k was clamped.
REQ-019 Two-stage pipeline: S1 registers products and coef-aligned valid; S2 registers rounded/saturated result.
REQ-020 Latency exactly 2 cycles from accepted input beat to out_valid when out_ready held high.
REQ-021 Throughput one beat per cycle with out_ready high; beats never dropped, duplicated or reordered.
REQ-022 Stall rule: S2 advances when !v2 || out_ready; S1 advances when !v1 || S2 advances; in_ready = !v1 || S2 advances.
REQ-023 out_pixel/sat_flag held stable while out_valid && !out_ready.
REQ-024 Simultaneous accept and emit in the same cycle is legal and preserves full throughput.
REQ-025 in_pixel and coef ignored when in_valid low; no state change.

Reset
REQ-026 rst_n low clears v1, v2, out_valid, out_pixel, sat_flag to 0 immediately; in_ready=1 after reset.
REQ-027 Reset mid-operation discards all in-flight beats; first output after release comes only from a newly accepted beat.

Configuration
REQ-028 Macro PIXEL_SCALE_SAT_EN defined: saturation per REQ-018.
REQ-029 Macro undefined: result is the low OUT_W bits of the rounded value (two's-complement wrap), sat_flag tied 0.

Structure
REQ-030 Shared package pixel_scale_pkg holds default parameter constants and the round/saturate width helper constants.
REQ-031 One sub-module pixel_scale_lane (multiply, round, clamp for a single lane), instantiated LANES times via generate; handshake logic stays in the top.

Verification (defaults, coef 64 = 1.0)
REQ-032 Reset: rst_n low -> out_valid=0, out_pixel=0, sat_flag=0, in_ready=1.
REQ-033 Arithmetic: lane0 pixel 50 coef 64 -> 50; pixel -37 coef 32 -> -18; both appear 2 cycles after accept.
REQ-034 Saturation: pixel 100 coef 127 -> 127, sat_flag=1; pixel -128 coef -128 -> 127, sat_flag=1; without macro -> -58 and 0, sat_flag=0.
REQ-035 Backpressure: out_ready low 5 cycles while 3 beats offered -> 2 accepted, in_ready low, outputs stable; on release all 3 emitted in order.
REQ-036 Streaming: 16 consecutive beats, out_ready high -> 16 outputs on consecutive cycles, first 2 cycles after first accept.
REQ-037 Reset mid-stream: pulse rst_n with 2 beats in flight -> none emitted; new beat after release emitted with latency 2.
